// File: rtl/rvfpm_xif_queue.sv
`default_nettype none
// ============================================================================
// Module      : rvfpm_xif_queue
// Description : XIF issue/commit front end for the FPU coprocessor. Issued
//               instructions and their operands enter an in-order circular
//               queue, are resolved by commit/kill through their ID, and
//               committed entries leave from the head towards execute.
// Revision    : 1.0 - initial release
// ============================================================================
module rvfpm_xif_queue #(
    parameter int QUEUE_DEPTH = 4,
    parameter int X_ID_WIDTH  = 4,
    parameter int X_NUM_RS    = 3,
    parameter int XLEN        = 32
) (
    input  logic                             ck,
    input  logic                             rst_n,
    input  logic                             issue_valid,
    output logic                             issue_ready,
    input  logic [31:0]                      issue_instr,
    input  logic [X_ID_WIDTH-1:0]            issue_id,
    input  logic [X_NUM_RS*XLEN-1:0]         issue_rs,
    input  logic [X_NUM_RS-1:0]              issue_rs_valid,
    input  logic                             pd_accept,
    input  logic [X_NUM_RS-1:0]              pd_use_rs,
    output logic                             issue_accept,
    input  logic                             commit_valid,
    input  logic [X_ID_WIDTH-1:0]            commit_id,
    input  logic                             commit_kill,
    output logic                             ex_valid,
    input  logic                             ex_ready,
    output logic [31:0]                      ex_instr,
    output logic [X_ID_WIDTH-1:0]            ex_id,
    output logic [X_NUM_RS*XLEN-1:0]         ex_rs,
    output logic [$clog2(QUEUE_DEPTH):0]     q_count,
    output logic                             commit_miss
);

    localparam int IDX_W = $clog2(QUEUE_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam int RS_W  = X_NUM_RS * XLEN;

    // Entry storage and pointers (MSB of each pointer is the wrap bit)
    logic [QUEUE_DEPTH-1:0][31:0]           instr_q,     instr_d;
    logic [QUEUE_DEPTH-1:0][X_ID_WIDTH-1:0] id_q,        id_d;
    logic [QUEUE_DEPTH-1:0][RS_W-1:0]       rs_q,        rs_d;
    logic [QUEUE_DEPTH-1:0]                 valid_q,     valid_d;
    logic [QUEUE_DEPTH-1:0]                 committed_q, committed_d;
    logic [QUEUE_DEPTH-1:0]                 killed_q,    killed_d;
    logic [PTR_W-1:0]                       wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]                       rd_ptr_q,    rd_ptr_d;
    logic [PTR_W-1:0]                       count_q,     count_d;
    logic                                   commit_miss_q, commit_miss_d;

    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] commit_idx;
    logic             full;
    logic             id_hit;
    logic             rs_ok;
    logic             push;
    logic             pop;
    logic             drain;
    logic             head_valid;
    logic             commit_hit;
    logic             bypass;
    logic [RS_W-1:0]  rs_masked;

    // Issue-side handshake, hazard detection and operand masking
    always_comb begin
        head_idx = rd_ptr_q[IDX_W-1:0];
        wr_idx   = wr_ptr_q[IDX_W-1:0];
        full     = (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]) &&
                   (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
        id_hit   = 1'b0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (valid_q[i] && (id_q[i] == issue_id)) begin
                id_hit = 1'b1;
            end
        end
        rs_ok     = &(~pd_use_rs | issue_rs_valid);
        // A full queue stays closed even while its head leaves this cycle
        issue_ready  = rst_n & ~full & ~id_hit & rs_ok;
        issue_accept = pd_accept;
        push         = issue_valid & issue_ready & pd_accept;
        rs_masked    = '0;
        for (int i = 0; i < X_NUM_RS; i++) begin
            if (pd_use_rs[i]) begin
                rs_masked[i*XLEN +: XLEN] = issue_rs[i*XLEN +: XLEN];
            end
        end
    end

    // Commit lookup across queued entries plus bypass onto the entry being pushed
    always_comb begin
        commit_hit = 1'b0;
        commit_idx = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (valid_q[i] && (id_q[i] == commit_id)) begin
                commit_hit = 1'b1;
                commit_idx = IDX_W'(i);
            end
        end
        bypass = push & commit_valid & (commit_id == issue_id);
    end

    // Head status: dispatch committed entries, silently drop killed ones
    always_comb begin
        head_valid = valid_q[head_idx];
        ex_valid   = head_valid & committed_q[head_idx] & ~killed_q[head_idx];
        drain      = head_valid & killed_q[head_idx];
        pop        = (ex_valid & ex_ready) | drain;
        ex_instr   = instr_q[head_idx];
        ex_id      = id_q[head_idx];
        ex_rs      = rs_q[head_idx];
        q_count    = count_q;
        commit_miss = commit_miss_q;
    end

    // Next-state for entries, pointers, occupancy and the miss pulse
    always_comb begin
        instr_d     = instr_q;
        id_d        = id_q;
        rs_d        = rs_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        killed_d    = killed_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        // Entries already resolved ignore further commits; a hit on them is not a miss
        if (commit_valid && commit_hit &&
            !committed_q[commit_idx] && !killed_q[commit_idx]) begin
            committed_d[commit_idx] = ~commit_kill;
            killed_d[commit_idx]    = commit_kill;
        end

        if (pop) begin
            valid_d[head_idx]     = 1'b0;
            committed_d[head_idx] = 1'b0;
            killed_d[head_idx]    = 1'b0;
            rd_ptr_d              = rd_ptr_q + PTR_W'(1);
        end

        // Push slot never aliases the head being popped: a pop implies non-empty,
        // a push implies non-full
        if (push) begin
            instr_d[wr_idx]     = issue_instr;
            id_d[wr_idx]        = issue_id;
            rs_d[wr_idx]        = rs_masked;
            valid_d[wr_idx]     = 1'b1;
            committed_d[wr_idx] = bypass & ~commit_kill;
            killed_d[wr_idx]    = bypass & commit_kill;
            wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        end

        count_d       = count_q + PTR_W'(push) - PTR_W'(pop);
        commit_miss_d = commit_valid & ~commit_hit & ~bypass;
    end

    // State registers, cleared asynchronously
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            instr_q       <= '0;
            id_q          <= '0;
            rs_q          <= '0;
            valid_q       <= '0;
            committed_q   <= '0;
            killed_q      <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            commit_miss_q <= 1'b0;
        end else begin
            instr_q       <= instr_d;
            id_q          <= id_d;
            rs_q          <= rs_d;
            valid_q       <= valid_d;
            committed_q   <= committed_d;
            killed_q      <= killed_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            commit_miss_q <= commit_miss_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rvfpm_xif_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_rvfpm_xif_queue
// Description : Directed self-checking bench for rvfpm_xif_queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rvfpm_xif_queue;

    logic        ck = 1'b0;
    logic        rst_n;
    logic        issue_valid;
    logic        issue_ready;
    logic [31:0] issue_instr;
    logic [3:0]  issue_id;
    logic [95:0] issue_rs;
    logic [2:0]  issue_rs_valid;
    logic        pd_accept;
    logic [2:0]  pd_use_rs;
    logic        issue_accept;
    logic        commit_valid;
    logic [3:0]  commit_id;
    logic        commit_kill;
    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_instr;
    logic [3:0]  ex_id;
    logic [95:0] ex_rs;
    logic [2:0]  q_count;
    logic        commit_miss;

    int errors = 0;
    int checks = 0;

    rvfpm_xif_queue #(
        .QUEUE_DEPTH(4), .X_ID_WIDTH(4), .X_NUM_RS(3), .XLEN(32)
    ) dut (
        .ck(ck), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_instr(issue_instr), .issue_id(issue_id),
        .issue_rs(issue_rs), .issue_rs_valid(issue_rs_valid),
        .pd_accept(pd_accept), .pd_use_rs(pd_use_rs),
        .issue_accept(issue_accept),
        .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
        .ex_id(ex_id), .ex_rs(ex_rs), .q_count(q_count), .commit_miss(commit_miss)
    );

    always #5 ck = ~ck;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic idle_inputs();
        issue_valid    = 1'b0;
        issue_instr    = 32'h0;
        issue_id       = 4'h0;
        issue_rs       = 96'h0;
        issue_rs_valid = 3'b111;
        pd_accept      = 1'b1;
        pd_use_rs      = 3'b111;
        commit_valid   = 1'b0;
        commit_id      = 4'h0;
        commit_kill    = 1'b0;
        ex_ready       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic set_issue(input logic [3:0] id, input logic [31:0] instr);
        issue_valid = 1'b1;
        issue_id    = id;
        issue_instr = instr;
        issue_rs    = {28'h0, id, 28'h0, id, 28'h0, id};
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        issue_valid = 1'b1;
        issue_id = 4'h1;
        tick();
        checks++;
        if (q_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", q_count); end
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid: got %b expected 0", ex_valid); end
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL reset_issue_ready: got %b expected 0", issue_ready); end
        checks++;
        if (commit_miss !== 1'b0) begin errors++; $display("FAIL reset_commit_miss: got %b expected 0", commit_miss); end
        issue_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_reset();
        issue_valid = 1'b1;
        issue_id    = 4'h1;
        issue_instr = 32'h0020_8053;
        issue_rs    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", issue_ready); end
        checks++;
        if (issue_accept !== 1'b1) begin errors++; $display("FAIL basic_accept: got %b expected 1", issue_accept); end
        tick();
        issue_valid = 1'b0;
        checks++;
        if (q_count !== 3'd1) begin errors++; $display("FAIL basic_count1: got %0d expected 1", q_count); end
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_uncommitted: got %b expected 0", ex_valid); end
        commit_valid = 1'b1;
        commit_id    = 4'h1;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL basic_ex_valid: got %b expected 1", ex_valid); end
        checks++;
        if (ex_id !== 4'h1) begin errors++; $display("FAIL basic_ex_id: got %0h expected 1", ex_id); end
        checks++;
        if (ex_rs !== {32'h3333_3333, 32'h2222_2222, 32'h1111_1111}) begin
            errors++; $display("FAIL basic_ex_rs: got %h expected 333333332222222211111111", ex_rs);
        end
        checks++;
        if (ex_instr !== 32'h0020_8053) begin errors++; $display("FAIL basic_ex_instr: got %h expected 00208053", ex_instr); end
        checks++;
        if (commit_miss !== 1'b0) begin errors++; $display("FAIL basic_no_miss: got %b expected 0", commit_miss); end
        tick();
        checks++;
        if (ex_valid !== 1'b1 || ex_id !== 4'h1) begin
            errors++; $display("FAIL basic_hold: got valid=%b id=%0h expected valid=1 id=1", ex_valid, ex_id);
        end
        ex_ready = 1'b1;
        tick();
        ex_ready = 1'b0;
        checks++;
        if (q_count !== 3'd0) begin errors++; $display("FAIL basic_count0: got %0d expected 0", q_count); end
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL basic_popped: got %b expected 0", ex_valid); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 1; i <= 4; i++) begin
            set_issue(4'(i), 32'h0000_0053);
            tick();
        end
        checks++;
        if (q_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", q_count); end
        set_issue(4'h5, 32'h0000_0053);
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b expected 0", issue_ready); end
        issue_valid  = 1'b0;
        commit_valid = 1'b1;
        commit_id    = 4'h1;
        tick();
        commit_valid = 1'b0;
        ex_ready     = 1'b1;
        issue_valid  = 1'b1;
        #1;
        checks++;
        if (ex_valid !== 1'b1) begin errors++; $display("FAIL full_head_valid: got %b expected 1", ex_valid); end
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL full_pop_cycle_ready: got %b expected 0", issue_ready); end
        tick();
        ex_ready = 1'b0;
        #1;
        checks++;
        if (q_count !== 3'd3) begin errors++; $display("FAIL full_count3: got %0d expected 3", q_count); end
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL full_after_pop_ready: got %b expected 1", issue_ready); end
        issue_valid = 1'b0;
    endtask

    task automatic test_kill();
        do_reset();
        set_issue(4'h2, 32'h0000_0153);
        tick();
        set_issue(4'h3, 32'h0000_0253);
        tick();
        issue_valid  = 1'b0;
        commit_valid = 1'b1;
        commit_id    = 4'h2;
        commit_kill  = 1'b1;
        ex_ready     = 1'b1;
        tick();
        commit_id    = 4'h3;
        commit_kill  = 1'b0;
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL kill_no_ex_valid: got %b expected 0", ex_valid); end
        checks++;
        if (q_count !== 3'd2) begin errors++; $display("FAIL kill_count2: got %0d expected 2", q_count); end
        ex_ready = 1'b0;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (q_count !== 3'd1) begin errors++; $display("FAIL kill_drained: got %0d expected 1", q_count); end
        checks++;
        if (ex_valid !== 1'b1 || ex_id !== 4'h3) begin
            errors++; $display("FAIL kill_next: got valid=%b id=%0h expected valid=1 id=3", ex_valid, ex_id);
        end
    endtask

    task automatic test_operands();
        do_reset();
        set_issue(4'h5, 32'h0000_0353);
        issue_rs       = {32'hDEAD_BEEF, 32'hBBBB_0002, 32'hAAAA_0001};
        pd_use_rs      = 3'b011;
        issue_rs_valid = 3'b001;
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL opnd_blocked: got %b expected 0", issue_ready); end
        issue_rs_valid = 3'b011;
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin errors++; $display("FAIL opnd_ready: got %b expected 1", issue_ready); end
        tick();
        issue_valid  = 1'b0;
        commit_valid = 1'b1;
        commit_id    = 4'h5;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (ex_rs !== {32'h0, 32'hBBBB_0002, 32'hAAAA_0001}) begin
            errors++; $display("FAIL opnd_masked: got %h expected 00000000bbbb0002aaaa0001", ex_rs);
        end
        pd_use_rs = 3'b111;
    endtask

    task automatic test_bypass();
        do_reset();
        set_issue(4'h7, 32'h0000_0453);
        commit_valid = 1'b1;
        commit_id    = 4'h7;
        tick();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        checks++;
        if (ex_valid !== 1'b1 || ex_id !== 4'h7) begin
            errors++; $display("FAIL bypass_committed: got valid=%b id=%0h expected valid=1 id=7", ex_valid, ex_id);
        end
        checks++;
        if (commit_miss !== 1'b0) begin errors++; $display("FAIL bypass_no_miss: got %b expected 0", commit_miss); end
        commit_valid = 1'b1;
        commit_id    = 4'h9;
        tick();
        commit_valid = 1'b0;
        checks++;
        if (commit_miss !== 1'b1) begin errors++; $display("FAIL miss_pulse: got %b expected 1", commit_miss); end
        tick();
        checks++;
        if (commit_miss !== 1'b0) begin errors++; $display("FAIL miss_one_cycle: got %b expected 0", commit_miss); end
        set_issue(4'h7, 32'h0000_0453);
        #1;
        checks++;
        if (issue_ready !== 1'b0) begin errors++; $display("FAIL dup_id_blocked: got %b expected 0", issue_ready); end
        set_issue(4'h8, 32'h0000_0000);
        pd_accept = 1'b0;
        #1;
        checks++;
        if (issue_ready !== 1'b1 || issue_accept !== 1'b0) begin
            errors++; $display("FAIL reject_handshake: got ready=%b accept=%b expected ready=1 accept=0", issue_ready, issue_accept);
        end
        tick();
        issue_valid = 1'b0;
        pd_accept   = 1'b1;
        checks++;
        if (q_count !== 3'd1) begin errors++; $display("FAIL reject_not_stored: got %0d expected 1", q_count); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_issue(4'(i), 32'h0000_0053);
            commit_valid = (i == 1);
            commit_id    = 4'h1;
            tick();
        end
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
        checks++;
        if (q_count !== 3'd3 || ex_valid !== 1'b1) begin
            errors++; $display("FAIL mid_prefill: got count=%0d valid=%b expected count=3 valid=1", q_count, ex_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (q_count !== 3'd0) begin errors++; $display("FAIL mid_reset_count: got %0d expected 0", q_count); end
        checks++;
        if (ex_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_ex_valid: got %b expected 0", ex_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (ex_valid !== 1'b0 || q_count !== 3'd0) begin
            errors++; $display("FAIL mid_after_release: got valid=%b count=%0d expected valid=0 count=0", ex_valid, q_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_kill();
        test_operands();
        test_bypass();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
